// File: rtl/nn_pkg.sv
// Shared constants, Q5.11 word type and loader FSM encoding for the MNIST
// pixel loader feeding neural_network.
package nn_pkg;

  localparam int unsigned INPUT_NEURONS = 784;
  localparam int unsigned WEIGHT_WIDTH  = 16;
  localparam int unsigned INT_WIDTH     = 5;
  localparam int unsigned FRACT_WIDTH   = 11;
  localparam int unsigned PIXEL_WIDTH   = 8;
  localparam int unsigned PIX_SHIFT     = 5;

  typedef logic signed [15:0] q5_11_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StWaitDone,
    StDrain
  } loader_state_e;

endpackage

// File: rtl/pixel_quantizer.sv
// Combinational byte -> Q5.11 conversion: zero-extend and shift left, so the
// result is always non-negative (255 -> 16'h1FE0).
module pixel_quantizer #(
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned PIX_SHIFT    = 5
) (
  input  logic [PIXEL_WIDTH-1:0]  pixel,
  output logic [WEIGHT_WIDTH-1:0] word
);

  logic [WEIGHT_WIDTH-1:0] pixel_ext;

  assign pixel_ext = {{(WEIGHT_WIDTH - PIXEL_WIDTH){1'b0}}, pixel};
  assign word      = pixel_ext << PIX_SHIFT;

endmodule

// File: rtl/nn_pixel_loader.sv
// Streams one grayscale frame into the accelerator input buffer, launches the
// accelerator when the frame is complete and waits for its done edge.
module nn_pixel_loader #(
  parameter int unsigned INPUT_NEURONS = nn_pkg::INPUT_NEURONS,
  parameter int unsigned WEIGHT_WIDTH  = nn_pkg::WEIGHT_WIDTH,
  parameter int unsigned PIXEL_WIDTH   = nn_pkg::PIXEL_WIDTH,
  parameter int unsigned PIX_SHIFT     = nn_pkg::PIX_SHIFT,
  parameter int unsigned ADDR_WIDTH    = $clog2(INPUT_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PIXEL_WIDTH-1:0]  s_data,
  input  logic                    s_last,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [WEIGHT_WIDTH-1:0] wr_data,
  output logic                    start,
  input  logic                    nn_done,
  output logic                    busy,
  output logic                    len_err,
  output logic [15:0]             frames_ok
);

  import nn_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(INPUT_NEURONS - 1);

  loader_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
  logic                    ready_q;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WEIGHT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [WEIGHT_WIDTH-1:0] pix_word;
  logic                    len_err_q, len_err_d;
  logic                    busy_q;
  logic [15:0]             frames_q;
  logic                    done_q;
  logic                    accept;
  logic                    done_rise;

  pixel_quantizer #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .PIX_SHIFT    (PIX_SHIFT)
  ) u_quant (
    .pixel (s_data),
    .word  (pix_word)
  );

  assign accept    = s_valid & ready_q;
  assign done_rise = nn_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    len_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          if (s_last) begin
            len_err_d = 1'b1;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = ADDR_WIDTH'(1);
            state_d   = StLoad;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_cnt_q;
          if (pix_cnt_q == LastIdx) begin
            pix_cnt_d = '0;
            len_err_d = ~s_last;
            state_d   = s_last ? StLaunch : StDrain;
          end else if (s_last) begin
            pix_cnt_d = '0;
            len_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Excess bytes of a long frame are swallowed; the first frame's worth is kept.
        if (accept && s_last) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (done_rise) begin
          pix_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign wr_data_d = wr_en_d ? pix_word : wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pix_cnt_q <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
      frames_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      ready_q   <= (state_d == StIdle) || (state_d == StLoad) || (state_d == StDrain);
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_err_q <= len_err_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= nn_done;
      if (state_q == StLaunch) begin
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  assign s_ready   = ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign start     = (state_q == StLaunch);
  assign busy      = busy_q;
  assign len_err   = len_err_q;
  assign frames_ok = frames_q;

endmodule

// File: tb/tb_nn_pixel_loader.sv
// Directed bench for nn_pixel_loader: good, short and long frames, pixel mapping,
// backpressure during WAIT_DONE and mid-frame reset.
module tb_nn_pixel_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        nn_done;
  logic        busy;
  logic        len_err;
  logic [15:0] frames_ok;

  int errors = 0;
  int checks = 0;

  nn_pixel_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .nn_done   (nn_done),
    .busy      (busy),
    .len_err   (len_err),
    .frames_ok (frames_ok)
  );

  always #5 clk = ~clk;

  // Observation of the buffer write port, sampled on the falling edge.
  logic [15:0] mem [0:1023];
  int cyc = 0;
  int wr_cnt, addr_err, start_cnt, len_cnt;
  int first_addr, last_addr, wr783_cyc, wr99_cyc, start_cyc, len_cyc, start_long;
  logic start_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (wr_en) begin
        mem[wr_addr] = wr_data;
        if (wr_cnt == 0) first_addr = int'(wr_addr);
        else if (!(wr_addr == 10'd0 || int'(wr_addr) == last_addr + 1)) addr_err++;
        last_addr = int'(wr_addr);
        wr_cnt++;
        if (wr_addr == 10'd783) wr783_cyc = cyc;
        if (wr_addr == 10'd99) wr99_cyc = cyc;
      end
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
        if (start_prev) start_long++;
      end
      if (len_err) begin
        len_cnt++;
        len_cyc = cyc;
      end
    end
    start_prev = start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; addr_err = 0; start_cnt = 0; len_cnt = 0; start_long = 0;
    first_addr = -1; last_addr = -1; wr783_cyc = -1; wr99_cyc = -2;
    start_cyc = -3; len_cyc = -4;
    for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
  endtask

  function automatic logic [7:0] pix(input int mode, input int i);
    logic [7:0] tbl [4];
    tbl = '{8'd0, 8'd1, 8'd128, 8'd255};
    case (mode)
      0:       pix = 8'hFF;
      1:       pix = (i < 4) ? tbl[i] : (8'(i) ^ 8'h5A);
      default: pix = 8'(i * 7);
    endcase
  endfunction

  function automatic logic [15:0] q(input logic [7:0] p);
    q = {3'b000, p, 5'b00000};
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic l, inout int waits);
    int n;
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0;
    while (!s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    waits += n + 1;
  endtask

  task automatic send_frame(input int mode, input int nbeats, input int last_idx,
                            input bit gaps, output int waits);
    waits = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_beat(pix(mode, i), (i == last_idx), waits);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic done_pulse(input string tag);
    nn_done = 1'b0;
    @(negedge clk);
    nn_done = 1'b1;
    @(negedge clk);
    check({tag, "_ready_after_done"}, 32'(s_ready), 32'd1);
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int mode);
    int bad;
    bad = 0;
    for (int i = 0; i < 784; i++) if (mem[i] !== q(pix(mode, i))) bad++;
    check({tag, "_bad_entries"}, 32'(bad), 32'd0);
    check({tag, "_addr_seq"}, 32'(addr_err), 32'd0);
  endtask

  int  w;
  bit  acc_any;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; nn_done = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_frames_ok", 32'(frames_ok), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(s_ready), 32'd1);

    // Good frame, all 0xFF.
    clear_mon();
    send_frame(0, 784, 783, 1'b0, w);
    check("good_throughput", 32'(w), 32'd784);
    check("good_start_now", 32'(start), 32'd1);
    repeat (2) @(negedge clk);
    check("good_wr_cnt", 32'(wr_cnt), 32'd784);
    check("good_entry0", 32'(mem[0]), 32'h1FE0);
    check("good_entry783", 32'(mem[783]), 32'h1FE0);
    check_frame("good", 0);
    check("good_start_cnt", 32'(start_cnt), 32'd1);
    check("good_start_with_last_wr", 32'(start_cyc), 32'(wr783_cyc));
    check("good_start_width", 32'(start_long), 32'd0);
    check("good_len_err", 32'(len_cnt), 32'd0);
    check("good_frames_ok", 32'(frames_ok), 32'd1);
    check("good_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    check("good_ready_waiting", 32'(s_ready), 32'd0);
    done_pulse("good");

    // Pixel mapping frame; nn_done stays high afterwards.
    clear_mon();
    send_frame(1, 784, 783, 1'b0, w);
    repeat (2) @(negedge clk);
    check("map_px0", 32'(mem[0]), 32'h0000);
    check("map_px1", 32'(mem[1]), 32'h0020);
    check("map_px128", 32'(mem[2]), 32'h1000);
    check("map_px255", 32'(mem[3]), 32'h1FE0);
    check_frame("map", 1);
    check("map_frames_ok", 32'(frames_ok), 32'd2);

    // Second frame offered while waiting; stale high nn_done must not release it.
    acc_any = 1'b0;
    s_data = 8'h33;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      if (s_valid && s_ready) acc_any = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("bp_no_accept", 32'(acc_any), 32'd0);
    check("bp_no_write", 32'(wr_cnt), 32'd784);
    check("bp_ready_low", 32'(s_ready), 32'd0);
    done_pulse("bp");

    clear_mon();
    send_frame(2, 784, 783, 1'b1, w);
    repeat (2) @(negedge clk);
    check("bp_wr_cnt", 32'(wr_cnt), 32'd784);
    check_frame("bp", 2);
    check("bp_start_cnt", 32'(start_cnt), 32'd1);
    check("bp_frames_ok", 32'(frames_ok), 32'd3);
    done_pulse("bp2");

    // Short frame: s_last on beat 100.
    clear_mon();
    send_frame(2, 100, 99, 1'b0, w);
    check("short_len_err_now", 32'(len_err), 32'd1);
    repeat (3) @(negedge clk);
    check("short_wr_cnt", 32'(wr_cnt), 32'd100);
    check("short_len_cnt", 32'(len_cnt), 32'd1);
    check("short_len_with_wr", 32'(len_cyc), 32'(wr99_cyc));
    check("short_no_start", 32'(start_cnt), 32'd0);
    check("short_ready", 32'(s_ready), 32'd1);
    check("short_busy", 32'(busy), 32'd0);
    check("short_frames_ok", 32'(frames_ok), 32'd3);
    clear_mon();
    send_frame(1, 784, 783, 1'b0, w);
    repeat (2) @(negedge clk);
    check("after_short_first_addr", 32'(first_addr), 32'd0);
    check_frame("after_short", 1);
    check("after_short_start", 32'(start_cnt), 32'd1);
    check("after_short_frames_ok", 32'(frames_ok), 32'd4);
    done_pulse("after_short");

    // Long frame: 790 bytes, s_last on the 790th.
    clear_mon();
    send_frame(2, 790, 789, 1'b0, w);
    check("long_throughput", 32'(w), 32'd790);
    repeat (2) @(negedge clk);
    check("long_wr_cnt", 32'(wr_cnt), 32'd784);
    check("long_len_cnt", 32'(len_cnt), 32'd1);
    check("long_len_at_784", 32'(len_cyc), 32'(wr783_cyc));
    check_frame("long", 2);
    check("long_start_cnt", 32'(start_cnt), 32'd1);
    check("long_frames_ok", 32'(frames_ok), 32'd5);
    done_pulse("long");

    // Reset asserted after 400 pixels.
    clear_mon();
    send_frame(0, 400, -1, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frames_ok", 32'(frames_ok), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    send_frame(2, 784, 783, 1'b0, w);
    repeat (2) @(negedge clk);
    check("midrst_first_addr", 32'(first_addr), 32'd0);
    check("midrst_wr_cnt", 32'(wr_cnt), 32'd784);
    check_frame("midrst", 2);
    check("midrst_frames_after", 32'(frames_ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_pixel_loader.md
# nn_pixel_loader

Upstream feeder for `neural_network`. Accepts an 8-bit grayscale MNIST frame (784 pixels, row-major) over a valid/ready byte stream. Converts each pixel to the accelerator's signed Q5.11 input format and writes it into the 784-entry input buffer. Pulses `start` once the frame is complete, then holds off the next frame until the accelerator reports `done`.

## Interface
Parameters:
- `INPUT_NEURONS`, 784: pixels per frame; buffer depth.
- `WEIGHT_WIDTH`, 16: input word width (Q5.11).
- `PIXEL_WIDTH`, 8: stream byte width.
- `PIX_SHIFT`, 5: left shift applied to each pixel (255 -> 16'h1FE0).
- `ADDR_WIDTH`, $clog2(INPUT_NEURONS) = 10: buffer address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `s_valid`, in, 1: pixel byte valid.
- `s_ready`, out, 1: loader accepts the byte this cycle.
- `s_data`, in, PIXEL_WIDTH: unsigned pixel value.
- `s_last`, in, 1: marks the final byte of a frame.
- `wr_en`, out, 1: input buffer write strobe.
- `wr_addr`, out, ADDR_WIDTH: buffer index 0..783.
- `wr_data`, out, WEIGHT_WIDTH: Q5.11 pixel.
- `start`, out, 1: one-cycle pulse to the accelerator.
- `nn_done`, in, 1: accelerator done level.
- `busy`, out, 1: high from the first accepted byte until `nn_done` rises.
- `len_err`, out, 1: one-cycle pulse on a malformed frame.
- `frames_ok`, out, 16: count of frames launched; wraps at 2^16.

## Operation
- **States:**
  - IDLE: `s_ready`=1.
  - LOAD: `s_ready`=1.
  - LAUNCH: `s_ready`=0.
  - WAIT_DONE: `s_ready`=0.
  - DRAIN: `s_ready`=1; bytes are discarded.
- **Beat acceptance:** a beat is accepted when `s_valid && s_ready`. Pixel counter `pix_cnt` (ADDR_WIDTH) starts at 0.
- **IDLE:** the first accepted beat writes address 0, sets `pix_cnt`=1 and moves to LOAD. If that beat also carries `s_last`, it takes the short-frame path below.
- **LOAD:** each accepted beat writes `wr_addr`=`pix_cnt`, `wr_data`={3'b0, s_data, 5'b0}, then increments `pix_cnt`.
- **Good frame:** beat with `pix_cnt`=783 and `s_last`=1. Go to LAUNCH.
- **Short frame:** `s_last`=1 with `pix_cnt`<783.
  - Write that beat.
  - Zero-fill is not performed; stale buffer entries remain.
  - Pulse `len_err`, reset `pix_cnt`, return to IDLE. No launch.
- **Long frame:** beat 783 without `s_last`.
  - Write it, pulse `len_err`, go to DRAIN.
  - DRAIN discards beats until a beat with `s_last`, then goes to LAUNCH. The first 784 pixels are used.
- **LAUNCH:** `start`=1 for exactly one cycle, `frames_ok`+1, go to WAIT_DONE.
- **WAIT_DONE:** leave on the rising edge of `nn_done` (edge detected against a registered copy), then go to IDLE with `pix_cnt`=0.
  - A `nn_done` level already high on entry is ignored.
- **Arithmetic:** unsigned zero-extension; the result is always non-negative. Maximum 16'h1FE0 = 3.984 in Q5.11.
- **Reset mid-frame:** all state is lost, and the next byte is treated as pixel 0. Buffer contents are not cleared.

## Timing
- Reset values:
  - `s_ready`=0 while `rst_n`=0, and 1 in the first cycle after release (IDLE).
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `start`=0, `busy`=0, `len_err`=0, `frames_ok`=0.
- Write outputs are registered: a beat accepted in cycle N appears as `wr_en`/`wr_addr`/`wr_data` in cycle N+1.
- `s_ready` is registered from the state only, never from `s_valid`.
- Throughput: one pixel per cycle, no bubbles, in IDLE, LOAD and DRAIN.
- Launch timing for a good frame:
  - Last beat accepted in cycle N.
  - Final write in N+1; `start` also in N+1, with state LAUNCH in N+1.
  - The buffer write and the `start` pulse coincide. The accelerator samples `start` at the N+1 edge and reads the buffer no earlier than N+2, so this is safe.
- Minimum gap, last beat to next frame's first accepted beat: 3 cycles plus the accelerator run time.
- `len_err` for a short frame asserts in cycle N+1 alongside the final write.

## Structure
- Package `nn_pkg`:
  - Constants: INPUT_NEURONS, WEIGHT_WIDTH, INT_WIDTH=5, FRACT_WIDTH=11, PIX_SHIFT.
  - `typedef logic signed [15:0] q5_11_t`.
  - `loader_state_e` enum for the five states.
- Sub-module `pixel_quantizer`: combinational byte -> q5_11_t conversion. It is kept separate so a scaled or normalised variant can replace it later.
- Top-level integration:
  - `wr_*` drives the accelerator's `inputs[]` array through a write port, replacing the initial block.
  - `start` drives the accelerator's `start`.

## Test plan
- Reset then a good frame: 784 bytes, all 8'hFF, `s_last` on the 784th -> 784 writes of 16'h1FE0 at addresses 0..783; `start` pulse 1 cycle after the last beat; `frames_ok`=1; `s_ready`=0 until `nn_done` rises.
- Pixel mapping: bytes 0, 1, 128, 255 at addresses 0..3 -> 16'h0000, 16'h0020, 16'h1000, 16'h1FE0.
- Short frame: `s_last` on beat 100 -> `len_err` pulse, no `start`; the next 784-byte frame writes from address 0 and launches.
- Long frame: 790 bytes, `s_last` on the 790th -> `len_err` at beat 784; 6 bytes discarded; the buffer holds the first 784; a single `start` pulse.
- Backpressure: `s_valid` toggled randomly and a second frame presented during WAIT_DONE -> no accept until `nn_done` rises; `nn_done` held high from earlier has no effect.
- `rst_n` pulsed low at pixel 400 -> all outputs return to reset values immediately; the next frame starts at address 0; `frames_ok`=0.
